// File: rtl/op_mult_arbiter.sv
// Round-robin arbiter sharing one iterative shift-add multiplier between NUM_REQ requesters.
// Optional early termination on exhausted multiplier bits: define OP_MULT_ARB_EARLY_TERM_EN.
module op_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 3,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_op_a,
    input  logic [NUM_REQ*OP_W-1:0] req_op_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [2*OP_W-1:0]       rsp_product,
    output logic                    busy
);

    localparam int              CNT_W    = $clog2(OP_W + 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OP_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        RESP
    } state_t;

    state_t              state, state_next;
    logic [ID_W-1:0]     rr_ptr;
    logic [2*OP_W-1:0]   acc, a_sh, acc_step;
    logic [OP_W-1:0]     b_sh, b_next;
    logic [CNT_W-1:0]    cnt;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [OP_W-1:0]     op_a_sel, op_b_sel;
    logic                mul_done;

    // First valid requester at or after rr_ptr, wrapping around.
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_w;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_w       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(rr_ptr) + k) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (!grant_found && req_valid[idx_w]) begin
                grant_found = 1'b1;
                grant_idx   = idx_w;
            end
        end
    end

    always_comb begin
        op_a_sel  = '0;
        op_b_sel  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                op_a_sel = req_op_a[i*OP_W +: OP_W];
                op_b_sel = req_op_b[i*OP_W +: OP_W];
                req_ready[i] = (state == IDLE) && grant_found && !rst;
            end
        end
    end

    assign acc_step = b_sh[0] ? (acc + a_sh) : acc;
    assign b_next   = b_sh >> 1;

`ifdef OP_MULT_ARB_EARLY_TERM_EN
    assign mul_done = (cnt == CNT_ONE) || (b_next == '0);
`else
    assign mul_done = (cnt == CNT_ONE);
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_found) state_next = MUL;
            MUL:     if (mul_done)    state_next = RESP;
            RESP:    if (rsp_ready)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            rsp_id      <= '0;
            rsp_product <= '0;
            acc         <= '0;
            a_sh        <= '0;
            b_sh        <= '0;
            cnt         <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        a_sh   <= {{OP_W{1'b0}}, op_a_sel};
                        b_sh   <= op_b_sel;
                        acc    <= '0;
                        rsp_id <= grant_idx;
                        cnt    <= CNT_INIT;
                        rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
                    end
                end
                MUL: begin
                    acc  <= acc_step;
                    a_sh <= a_sh << 1;
                    b_sh <= b_next;
                    cnt  <= cnt - 1'b1;
                    if (mul_done) rsp_product <= acc_step;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_op_mult_arbiter.sv
// Scoreboard bench for op_mult_arbiter: a grant/pointer model predicts each handshake and
// product, and a separate monitor checks every response, its latency and its stability.
module tb_op_mult_arbiter;

    localparam int NUM_REQ = 4;
    localparam int OP_W    = 3;
    localparam int ID_W    = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OP_W-1:0] req_op_a;
    logic [NUM_REQ*OP_W-1:0] req_op_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [2*OP_W-1:0]       rsp_product;
    logic                    busy;

    op_mult_arbiter #(.NUM_REQ(NUM_REQ), .OP_W(OP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op_a    (req_op_a),
        .req_op_b    (req_op_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int product;
        int grant_cyc;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   m_ptr  = 0;
    bit   m_idle = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic int exp_lat(input logic [OP_W-1:0] b);
        int l;
        l = 1;
        for (int i = 0; i < OP_W; i++) if (b[i]) l = i + 1;
`ifdef OP_MULT_ARB_EARLY_TERM_EN
        return l;
`else
        return (l > 0) ? OP_W : OP_W;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Predictor: unit is free or busy; when free, the first valid requester from m_ptr wins.
    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_rdy;
        int                 g;
        exp_t               e;
        exp_rdy = '0;
        g       = -1;
        if (rst) begin
            exp_q.delete();
            m_ptr  = 0;
            m_idle = 1'b1;
            check("req_ready_in_reset", int'(req_ready), 0);
        end else begin
            if (m_idle) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NUM_REQ;
                    if (g < 0 && req_valid[idx]) begin
                        g            = idx;
                        exp_rdy[idx] = 1'b1;
                    end
                end
            end
            check("req_ready", int'(req_ready), int'(exp_rdy));
            if (g >= 0) begin
                e.id        = g;
                e.product   = int'(req_op_a[g*OP_W +: OP_W]) * int'(req_op_b[g*OP_W +: OP_W]);
                e.grant_cyc = cyc + 1;
                e.lat       = exp_lat(req_op_b[g*OP_W +: OP_W]);
                exp_q.push_back(e);
                grant_log.push_back(g);
                m_ptr  = (g + 1) % NUM_REQ;
                m_idle = 1'b0;
            end
            if (rsp_valid && rsp_ready) m_idle = 1'b1;
        end
    end

    // Monitor: compares each presented response against the scoreboard head.
    bit              prev_v = 1'b0;
    logic [ID_W-1:0] held_id;
    logic [2*OP_W-1:0] held_prod;

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else if (rsp_valid) begin
            if (!prev_v) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got id %0d product %0d, expected no response",
                             rsp_id, rsp_product);
                end else begin
                    check("rsp_id", int'(rsp_id), exp_q[0].id);
                    check("rsp_product", int'(rsp_product), exp_q[0].product);
                    check("rsp_latency", cyc - exp_q[0].grant_cyc, exp_q[0].lat);
                end
            end else begin
                check("rsp_id_hold", int'(rsp_id), int'(held_id));
                check("rsp_product_hold", int'(rsp_product), int'(held_prod));
            end
            held_id   = rsp_id;
            held_prod = rsp_product;
            prev_v    = 1'b1;
            if (rsp_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                prev_v = 1'b0;
            end
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic set_req(input int i, input int a, input int b);
        req_op_a[i*OP_W +: OP_W] = OP_W'(a);
        req_op_b[i*OP_W +: OP_W] = OP_W'(b);
    endtask

    task automatic wait_grants(input int n);
        int i;
        for (i = 0; i < 60 && grant_log.size() < n; i++) @(posedge clk);
        #1;
        if (grant_log.size() < n) timeout("wait_grant");
    endtask

    task automatic drain();
        int i;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (i = 0; i < 60 && (exp_q.size() != 0 || !m_idle); i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0 || !m_idle) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, int'(req_ready), 0);
        check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        check({tag, "_rsp_id"}, int'(rsp_id), 0);
        check({tag, "_rsp_product"}, int'(rsp_product), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int base;
        int exp_order [5];
        int i;
        exp_order = '{0, 1, 2, 3, 0};

        rst = 1'b1; req_valid = '0; req_op_a = '0; req_op_b = '0; rsp_ready = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single requester: 5*7, then 5*1.
        set_req(1, 5, 7);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        wait_grants(grant_log.size() + 1);
        req_valid = '0;
        drain();
        set_req(1, 5, 1);
        req_valid = 4'b0010;
        wait_grants(grant_log.size() + 1);
        req_valid = '0;
        drain();

        // All requesters valid straight out of reset: round-robin order.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) set_req(r, $urandom_range(7), $urandom_range(7));
        base      = grant_log.size();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        wait_grants(base + 5);
        req_valid = '0;
        for (int k = 0; k < 5; k++)
            if (grant_log.size() > base + k) check("grant_order", grant_log[base+k], exp_order[k]);
        drain();

        // 7*7 on requester 3 with back-pressure; other requesters wait.
        set_req(3, 7, 7);
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        wait_grants(grant_log.size() + 1);
        req_valid = 4'b0111;
        for (i = 0; i < 20 && !rsp_valid; i++) @(posedge clk);
        if (!rsp_valid) timeout("wait_rsp_valid");
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid", int'(rsp_valid), 1);
            check("bp_rsp_id", int'(rsp_id), 3);
            check("bp_rsp_product", int'(rsp_product), 49);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_accept_busy", int'(busy), 0);
        check("idle_after_accept_valid", int'(rsp_valid), 0);
        req_valid = '0;
        drain();

        // Reset during MUL discards the operation and restarts arbitration at 0.
        set_req(2, 6, 5);
        req_valid = 4'b0100;
        wait_grants(grant_log.size() + 1);
        req_valid = '0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        req_valid = 4'b0101;
        set_req(0, 3, 3);
        #1;
        check_outputs_zero("midreset");
        @(posedge clk);
        #1 rst = 1'b0;
        base = grant_log.size();
        wait_grants(base + 1);
        req_valid = '0;
        if (grant_log.size() > base) check("grant_after_reset", grant_log[base], 0);
        drain();

        // Zero operands back-to-back.
        set_req(0, 0, 6);
        set_req(1, 6, 0);
        req_valid = 4'b0011;
        wait_grants(grant_log.size() + 2);
        req_valid = '0;
        drain();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            req_valid = NUM_REQ'($urandom);
            req_op_a  = (NUM_REQ*OP_W)'($urandom);
            req_op_b  = (NUM_REQ*OP_W)'($urandom);
            rsp_ready = ($urandom_range(3) != 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/op_mult_arbiter.md
Name: op_mult_arbiter

Overview:
- Shares one iterative shift-add multiplier between NUM_REQ requesters.
- Each requester presents an operand pair (the op-mode fields of its request record).
- The block arbitrates round-robin, sequences the multiply over OP_W cycles and returns the product tagged with the requester id.
- Sits between the request-record producers and the result consumer.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- OP_W, 3, operand width in bits (>=1).
- ID_W, $clog2(NUM_REQ) (minimum 1), width of the response id.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request strobe.
- req_ready  output  NUM_REQ  per-requester accept, at most one bit high.
- req_op_a  input  NUM_REQ*OP_W  operand A; requester i uses slice [i*OP_W +: OP_W].
- req_op_b  input  NUM_REQ*OP_W  operand B; same slicing.
- rsp_valid  output  1  product valid.
- rsp_ready  input  1  consumer accepts product.
- rsp_id  output  ID_W  index of the requester that owns the product.
- rsp_product  output  2*OP_W  unsigned product A*B.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0.
  - Internal acc, a_sh, b_sh and cnt cleared.
- States: IDLE, MUL, RESP.
- IDLE:
  - Winner g is the first set req_valid bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally; no bit is set when no req_valid is high.
  - Handshake occurs on the edge where req_valid[g] & req_ready[g].
  - On handshake: a_sh<=zero-extended op_a[g], b_sh<=op_b[g], acc<=0, id<=g, cnt<=OP_W, rr_ptr<=(g+1) mod NUM_REQ, state->MUL.
- MUL, one step per cycle:
  - if b_sh[0]: acc<=acc+a_sh.
  - a_sh<=a_sh<<1 (2*OP_W wide, no overflow possible); b_sh<=b_sh>>1; cnt<=cnt-1.
  - When cnt==1, state->RESP and rsp_product<=final acc.
- RESP:
  - rsp_valid=1; rsp_id and rsp_product are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: state->IDLE, rsp_valid deasserts next cycle.
- Latency: handshake at edge t gives rsp_valid high from edge t+OP_W (OP_W MUL cycles, then RESP). Fixed, independent of operand values, unless the optional feature is compiled in.
- Throughput: one new grant per (OP_W+2) cycles at best, because IDLE costs one cycle. No grant is made while in MUL or RESP; req_ready is 0 outside IDLE.
- Boundary conditions:
  - Operands of zero still take full latency; product is 0.
  - Max operands: (2^OP_W-1)^2 fits in 2*OP_W bits.
  - A requester may drop req_valid before it is granted; there is no sticky request state.
  - Operands are sampled only at the handshake edge; later input changes have no effect.
  - NUM_REQ=1: rr_ptr stays 0; behaviour otherwise identical.
  - rsp_ready held high before RESP has no effect.
  - Reset mid-MUL/RESP: the in-flight operation is discarded with no response; arbitration restarts from requester 0.
  - Simultaneous requests: exactly one grant per handshake; ungranted requesters wait. Fairness guarantees each valid requester a grant within NUM_REQ grants.

Optional Feature:
- Macro: OP_MULT_ARB_EARLY_TERM_EN.
- Defined: in MUL, if the b_sh value being written (after shift) is zero, state->RESP on that edge with the updated acc. Latency becomes 1+index of the highest set bit of B, with a minimum of 1 MUL cycle (B=0 also takes 1 MUL cycle).
- Undefined: fixed OP_W MUL cycles as above.
- Products are identical in both builds.

Test Plan (NUM_REQ=4, OP_W=3):
- Assert rst mid-clock with no edge -> all outputs 0 immediately; busy=0.
- Requester 1 only, a=5, b=7, accepted at edge t -> rsp_valid high from edge t+3, rsp_id=1, rsp_product=35. Same a=5, b=1 with OP_MULT_ARB_EARLY_TERM_EN -> rsp_valid from edge t+1, rsp_product=5.
- All four req_valid held high from reset with rsp_ready=1 -> grant order 0,1,2,3,0. Each req_ready is one-hot and only in IDLE.
- a=7, b=7 on requester 3, rsp_ready held low 5 cycles -> rsp_valid, rsp_id=3 and rsp_product=49 all stable; req_ready=0 throughout; IDLE entered the cycle after rsp_ready rises.
- Requester 2 granted, rst pulsed during MUL, then requesters 0 and 2 valid -> no response for the aborted op; next grant goes to 0 (rr_ptr reset).
- a=0, b=6 and a=6, b=0 in back-to-back requests -> both products 0, each with full fixed latency (macro undefined).
